// File: rtl/wb_arbiter_pkg.sv
// wb_pkg: shared widths, source ids and holding-entry type for the writeback arbiter
package wb_pkg;
  localparam int DATA_W = 16;
  localparam int TAG_W = 6;
  localparam logic [1:0] SRC_MULT = 2'd0;
  localparam logic [1:0] SRC_ALU1 = 2'd1;
  localparam logic [1:0] SRC_ALU2 = 2'd2;
  localparam logic [1:0] SRC_ADDR = 2'd3;
  typedef struct packed {
    logic valid;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0] tag;
  } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: functional-unit result handshakes and the two CDB broadcast ports
interface wb_arbiter_if;
  import wb_pkg::*;
  logic mult_valid_wb, alu1_valid, alu2_valid, addr_valid;
  logic [DATA_W-1:0] mult_out, alu1_out, alu2_out, addr_out;
  logic [TAG_W-1:0] mult_tag, alu1_tag, alu2_tag, addr_tag;
  logic mult_ready, alu1_ready, alu2_ready, addr_ready;
  logic cdb0_valid, cdb1_valid;
  logic [DATA_W-1:0] cdb0_data, cdb1_data;
  logic [TAG_W-1:0] cdb0_tag, cdb1_tag;
  logic [1:0] cdb0_src, cdb1_src;
  modport slave (
    input mult_valid_wb, alu1_valid, alu2_valid, addr_valid,
    input mult_out, alu1_out, alu2_out, addr_out,
    input mult_tag, alu1_tag, alu2_tag, addr_tag,
    output mult_ready, alu1_ready, alu2_ready, addr_ready,
    output cdb0_valid, cdb1_valid, cdb0_data, cdb1_data,
    output cdb0_tag, cdb1_tag, cdb0_src, cdb1_src
  );
  modport master (
    output mult_valid_wb, alu1_valid, alu2_valid, addr_valid,
    output mult_out, alu1_out, alu2_out, addr_out,
    output mult_tag, alu1_tag, alu2_tag, addr_tag,
    input mult_ready, alu1_ready, alu2_ready, addr_ready,
    input cdb0_valid, cdb1_valid, cdb0_data, cdb1_data,
    input cdb0_tag, cdb1_tag, cdb0_src, cdb1_src
  );
endinterface

// File: rtl/wb_arbiter_rr_pick2.sv
// wb_rr_pick2: first two set request bits scanning upward (mod 4) from start
module wb_rr_pick2 (
  input  logic [3:0] req,
  input  logic [1:0] start,
  output logic       v0,
  output logic [1:0] id0,
  output logic       v1,
  output logic [1:0] id1
);
  always_comb begin
    v0 = 1'b0;
    id0 = '0;
    v1 = 1'b0;
    id1 = '0;
    for (int i = 0; i < 4; i++) begin
      if (req[start + 2'(i)]) begin
        if (!v0) begin
          v0 = 1'b1;
          id0 = start + 2'(i);
        end else if (!v1) begin
          v1 = 1'b1;
          id1 = start + 2'(i);
        end
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-port CDB writeback arbiter with per-source skid registers.
// Optional WB_MULT_PRIO_EN gives the multiplier unconditional ownership of CDB0.
module wb_arbiter
  import wb_pkg::*;
(
  input logic clk,
  input logic rst,
  wb_arbiter_if.slave bus
);
  logic [3:0] in_v, held, fresh, hreq, freq, gnt;
  logic [DATA_W-1:0] in_d [4];
  logic [TAG_W-1:0] in_t [4];
  logic [DATA_W-1:0] cand_d [4];
  logic [TAG_W-1:0] cand_t [4];
  wb_entry_t hold [4];
  wb_entry_t cdb0, cdb1;
  logic [1:0] src0, src1, rr_ptr;
  logic hv0, hv1, fv0, fv1, m0_v, m1_v, g0_v, g1_v, mult_cand;
  logic [1:0] hid0, hid1, fid0, fid1, m0_id, m1_id, g0_id, g1_id;
  assign in_v = {bus.addr_valid, bus.alu2_valid, bus.alu1_valid, bus.mult_valid_wb};
  assign in_d = '{bus.mult_out, bus.alu1_out, bus.alu2_out, bus.addr_out};
  assign in_t = '{bus.mult_tag, bus.alu1_tag, bus.alu2_tag, bus.addr_tag};
  for (genvar i = 0; i < 4; i++) begin : g_src
    assign held[i] = hold[i].valid;
    assign cand_d[i] = held[i] ? hold[i].data : in_d[i];
    assign cand_t[i] = held[i] ? hold[i].tag : in_t[i];
  end
  // A valid presented while the skid register is full is a protocol violation and is ignored
  assign fresh = in_v & ~held;
`ifdef WB_MULT_PRIO_EN
  assign mult_cand = held[SRC_MULT] | fresh[SRC_MULT];
  assign hreq = held & 4'b1110;
  assign freq = fresh & 4'b1110;
`else
  assign mult_cand = 1'b0;
  assign hreq = held;
  assign freq = fresh;
`endif
  wb_rr_pick2 u_pick_held (.req(hreq), .start(rr_ptr), .v0(hv0), .id0(hid0), .v1(hv1), .id1(hid1));
  wb_rr_pick2 u_pick_fresh (.req(freq), .start(rr_ptr), .v0(fv0), .id0(fid0), .v1(fv1), .id1(fid1));
  // Held entries outrank fresh ones: merge the two ordered pick lists, held first
  assign m0_v = hv0 | fv0;
  assign m0_id = hv0 ? hid0 : fid0;
  assign m1_v = hv1 | (hv0 ? fv0 : fv1);
  assign m1_id = hv1 ? hid1 : (hv0 ? fid0 : fid1);
  assign g0_v = mult_cand | m0_v;
  assign g0_id = mult_cand ? SRC_MULT : m0_id;
  assign g1_v = mult_cand ? m0_v : m1_v;
  assign g1_id = mult_cand ? m0_id : m1_id;
  assign gnt = (g0_v ? 4'(4'b1 << g0_id) : 4'b0) | (g1_v ? 4'(4'b1 << g1_id) : 4'b0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hold[i] <= '0;
      cdb0 <= '0;
      cdb1 <= '0;
      src0 <= '0;
      src1 <= '0;
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) hold[i].valid <= 1'b0;
        else if (fresh[i]) hold[i] <= '{1'b1, in_d[i], in_t[i]};
      end
      cdb0.valid <= g0_v;
      cdb1.valid <= g1_v;
      if (g0_v) begin
        cdb0.data <= cand_d[g0_id];
        cdb0.tag <= cand_t[g0_id];
        src0 <= g0_id;
      end
      if (g1_v) begin
        cdb1.data <= cand_d[g1_id];
        cdb1.tag <= cand_t[g1_id];
        src1 <= g1_id;
      end
      if (g1_v) rr_ptr <= g1_id + 2'd1;
      else if (g0_v) rr_ptr <= g0_id + 2'd1;
    end
  end
  assign bus.mult_ready = ~held[SRC_MULT];
  assign bus.alu1_ready = ~held[SRC_ALU1];
  assign bus.alu2_ready = ~held[SRC_ALU2];
  assign bus.addr_ready = ~held[SRC_ADDR];
  assign bus.cdb0_valid = cdb0.valid;
  assign bus.cdb0_data = cdb0.data;
  assign bus.cdb0_tag = cdb0.tag;
  assign bus.cdb0_src = src0;
  assign bus.cdb1_valid = cdb1.valid;
  assign bus.cdb1_data = cdb1.data;
  assign bus.cdb1_tag = cdb1.tag;
  assign bus.cdb1_src = src1;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus against a priority-key model of the writeback arbiter
module tb_wb_arbiter;
  import wb_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic vin [4];
  logic [15:0] din [4];
  logic [5:0] tin [4];
  wb_arbiter_if bus();
  wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.mult_valid_wb = vin[0];
  assign bus.alu1_valid = vin[1];
  assign bus.alu2_valid = vin[2];
  assign bus.addr_valid = vin[3];
  assign bus.mult_out = din[0];
  assign bus.alu1_out = din[1];
  assign bus.alu2_out = din[2];
  assign bus.addr_out = din[3];
  assign bus.mult_tag = tin[0];
  assign bus.alu1_tag = tin[1];
  assign bus.alu2_tag = tin[2];
  assign bus.addr_tag = tin[3];
  logic [3:0] rdy;
  assign rdy = {bus.addr_ready, bus.alu2_ready, bus.alu1_ready, bus.mult_ready};
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
    end
  endfunction
  // Model: each candidate gets a key (held 0..3, fresh 4..7, offset by distance from the
  // pointer); the two smallest keys win CDB0 then CDB1.
  logic m_hv [4];
  logic [15:0] m_hd [4];
  logic [5:0] m_ht [4];
  int m_ptr;
  int acc_q [4][$];
  logic e_v [2];
  logic [15:0] e_d [2];
  logic [5:0] e_t [2];
  logic [1:0] e_s [2];
  int key [4];
  int g [2];
  logic fr [4];
  logic [15:0] cd [4];
  logic [5:0] ct [4];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 4; s++) begin
        m_hv[s] = 1'b0;
        m_hd[s] = '0;
        m_ht[s] = '0;
        acc_q[s].delete();
      end
      for (int k = 0; k < 2; k++) begin
        e_v[k] = 1'b0;
        e_d[k] = '0;
        e_t[k] = '0;
        e_s[k] = '0;
      end
      m_ptr = 0;
    end else begin
      cyc++;
      for (int s = 0; s < 4; s++) begin
        fr[s] = vin[s] && !m_hv[s];
        cd[s] = m_hv[s] ? m_hd[s] : din[s];
        ct[s] = m_hv[s] ? m_ht[s] : tin[s];
        key[s] = (m_hv[s] || fr[s]) ? (m_hv[s] ? 0 : 4) + (s - m_ptr + 4) % 4 : 99;
`ifdef WB_MULT_PRIO_EN
        if (s == 0 && key[0] != 99) key[0] = -1;
`endif
        if (fr[s]) acc_q[s].push_back(cyc);
      end
      g[0] = -1;
      g[1] = -1;
      for (int k = 0; k < 2; k++)
        for (int s = 0; s < 4; s++)
          if (key[s] != 99 && s != g[0] && (g[k] < 0 || key[s] < key[g[k]])) g[k] = s;
      for (int k = 0; k < 2; k++) begin
        e_v[k] = g[k] >= 0;
        if (g[k] >= 0) begin
          e_d[k] = cd[g[k]];
          e_t[k] = ct[g[k]];
          e_s[k] = 2'(g[k]);
        end
      end
      for (int s = 0; s < 4; s++) begin
        if (s == g[0] || s == g[1]) m_hv[s] = 1'b0;
        else if (fr[s]) begin
          m_hv[s] = 1'b1;
          m_hd[s] = din[s];
          m_ht[s] = tin[s];
        end
      end
      if (g[1] >= 0) m_ptr = (g[1] + 1) % 4;
      else if (g[0] >= 0) m_ptr = (g[0] + 1) % 4;
    end
  end
  function automatic void sb_pop(logic [1:0] s);
    chk("sb_accepted", acc_q[s].size() > 0, 1);
    if (acc_q[s].size() > 0) chk("latency_le2", (cyc - acc_q[s].pop_front()) <= 2, 1);
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      chk("cdb0_valid", bus.cdb0_valid, e_v[0]);
      chk("cdb0_data", bus.cdb0_data, e_d[0]);
      chk("cdb0_tag", bus.cdb0_tag, e_t[0]);
      chk("cdb0_src", bus.cdb0_src, e_s[0]);
      chk("cdb1_valid", bus.cdb1_valid, e_v[1]);
      chk("cdb1_data", bus.cdb1_data, e_d[1]);
      chk("cdb1_tag", bus.cdb1_tag, e_t[1]);
      chk("cdb1_src", bus.cdb1_src, e_s[1]);
      for (int s = 0; s < 4; s++) chk($sformatf("ready%0d", s), rdy[s], !m_hv[s]);
      if (bus.cdb0_valid) sb_pop(bus.cdb0_src);
      if (bus.cdb1_valid) sb_pop(bus.cdb1_src);
    end
  end
  task automatic put(int s, logic [15:0] d, logic [5:0] t);
    vin[s] = 1'b1;
    din[s] = d;
    tin[s] = t;
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 4; s++) vin[s] = 1'b0;
  endtask
  int n1, n2, pending;
  initial begin
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      vin[s] = 1'b0;
      din[s] = '0;
      tin[s] = '0;
    end
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_cdb0_valid", bus.cdb0_valid, 0);
    chk("rst_cdb1_valid", bus.cdb1_valid, 0);
    chk("rst_cdb0_data", bus.cdb0_data, 0);
    chk("rst_cdb1_tag", bus.cdb1_tag, 0);
    chk("rst_ready", rdy, 4'hF);
    rst = 1'b0;
    put(0, 16'd180, 6'd5);
    tick();
    chk("single_v0", bus.cdb0_valid, 1);
    chk("single_data", bus.cdb0_data, 180);
    chk("single_tag", bus.cdb0_tag, 5);
    chk("single_src", bus.cdb0_src, 0);
    chk("single_v1", bus.cdb1_valid, 0);
    put(1, 16'hFFFF, 6'd3);
    put(2, 16'hB2B4, 6'd4);
    tick();
    chk("two_src0", bus.cdb0_src, 1);
    chk("two_data0", bus.cdb0_data, 16'hFFFF);
    chk("two_src1", bus.cdb1_src, 2);
    chk("two_data1", bus.cdb1_data, 16'hB2B4);
    chk("two_ready", rdy, 4'hF);
    put(3, 16'h0099, 6'd9);
    tick();
    chk("addr_src0", bus.cdb0_src, 3);
    put(0, 16'h0011, 6'd1);
    put(1, 16'h0022, 6'd2);
    put(2, 16'h0033, 6'd3);
    put(3, 16'h0044, 6'd4);
    tick();
    chk("four_a_tag0", bus.cdb0_tag, 1);
    chk("four_a_tag1", bus.cdb1_tag, 2);
    chk("four_a_ready", rdy, 4'b0011);
    tick();
    chk("four_b_src0", bus.cdb0_src, 2);
    chk("four_b_data0", bus.cdb0_data, 16'h0033);
    chk("four_b_src1", bus.cdb1_src, 3);
    chk("four_b_tag1", bus.cdb1_tag, 4);
    chk("four_b_ready", rdy, 4'hF);
    tick();
    chk("idle_v0", bus.cdb0_valid, 0);
    chk("idle_hold_tag1", bus.cdb1_tag, 4);
    put(0, 16'd7, 6'd7);
    tick();
    put(0, 16'd100, 6'd10);
    put(1, 16'd101, 6'd11);
    put(2, 16'd102, 6'd12);
    tick();
`ifdef WB_MULT_PRIO_EN
    chk("prio_src0", bus.cdb0_src, 0);
    chk("prio_src1", bus.cdb1_src, 1);
    chk("prio_ready", rdy, 4'b1011);
`else
    chk("prio_src0", bus.cdb0_src, 1);
    chk("prio_src1", bus.cdb1_src, 2);
    chk("prio_ready", rdy, 4'b1110);
`endif
    tick();
    tick();
    n1 = 0;
    n2 = 0;
    for (int i = 0; i < 8; i++) begin
      put(1, 16'(16'h100 + i), 6'(16 + i));
      put(2, 16'(16'h200 + i), 6'(32 + i));
      tick();
      n1 += int'(bus.cdb0_valid && bus.cdb0_src == 2'd1) + int'(bus.cdb1_valid && bus.cdb1_src == 2'd1);
      n2 += int'(bus.cdb0_valid && bus.cdb0_src == 2'd2) + int'(bus.cdb1_valid && bus.cdb1_src == 2'd2);
    end
    chk("fair_alu1", n1, 8);
    chk("fair_alu2", n2, 8);
    for (int i = 0; i < 12; i++) begin
      for (int s = 0; s < 3; s++)
        if (!m_hv[s]) put(s, 16'($urandom_range(0, 65535)), 6'($urandom_range(0, 63)));
      tick();
    end
    tick();
    tick();
    tick();
    pending = 0;
    for (int s = 0; s < 4; s++) pending += acc_q[s].size();
    chk("drained", pending, 0);
    for (int s = 0; s < 4; s++) put(s, 16'(16'hA0 + s), 6'(40 + s));
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_ready", rdy, 4'hF);
    chk("midrst_v0", bus.cdb0_valid, 0);
    chk("midrst_v1", bus.cdb1_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    chk("postrst_v0", bus.cdb0_valid, 0);
    chk("postrst_v1", bus.cdb1_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
